data_ram_ctrl: RTL and testbench
================================

Name: data_ram_ctrl

Overview:
- Data-memory responder for the MEM stage's data-memory port.
- Accepts ce/we/addr/sel/data requests from the MEM stage and holds a word-organised RAM with byte-lane writes.
- Returns full 32-bit read words after a programmable number of wait states.
- Raises a stall request toward pipeline control until each access completes.

Parameters:
- ADDR_WIDTH, 10, log2 of RAM depth in 32-bit words.
- WAIT_CYCLES, 1, extra wait states between request accept and completion (0..15).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- ce  input  1  chip enable; request valid (ChipEnable=1).
- we  input  1  1 = write, 0 = read.
- addr  input  32  byte address; word index = addr[ADDR_WIDTH+1:2]; higher bits ignored (wrap).
- data_i  input  32  write data, lanes already replicated by requester.
- sel  input  4  byte-lane select; sel[3]=bits 31:24 (byte offset 00), sel[0]=bits 7:0 (offset 11), big-endian.
- data_o  output  32  read word (full word, all lanes).
- ready  output  1  access completes this cycle.
- stall_req  output  1  requester must hold; = ce & ~ready (combinational).

Behaviour:
- Reset values (on rst=1 at clock edge): state IDLE, data_o 0, ready 0, wait counter 0, latched request cleared. stall_req follows ce & ~ready.
- RAM contents are not reset.
- States:
  - IDLE: ce=1 latches addr word index, we, sel, data_i. Goes to WAIT if WAIT_CYCLES>0, else ACCESS, and loads counter = WAIT_CYCLES.
  - WAIT: counter decrements each cycle; goes to ACCESS on the cycle it reaches 1.
  - ACCESS: ready=1 (decoded from state); always returns to IDLE next cycle.
- Latency: request accepted at cycle 0, ready high in cycle WAIT_CYCLES+1. Exactly one ready pulse per accepted request.
- Read data:
  - On the edge entering ACCESS with latched we=0, data_o <= RAM[latched index].
  - data_o holds its value until the next read; writes leave it unchanged.
  - sel does not mask reads.
- Write commit:
  - On the edge leaving ACCESS with latched we=1, each lane with sel[i]=1 gets the corresponding byte of latched data.
  - Lanes with sel[i]=0 are unchanged.
  - sel=0000 completes normally and modifies nothing.
- Input changes while busy: addr/we/sel/data_i changes after accept are ignored; latched values are used.
- Abort: ce=0 in WAIT or ACCESS returns to IDLE next edge, drops ready, and commits no write (including ce=0 during ACCESS).
- Back-to-back: the requester advances on ready. The IDLE cycle after ACCESS may accept a new request, so sustained throughput is one access per WAIT_CYCLES+2 cycles.
- Read-after-write to the same word returns the new data, because write commit precedes any later read load.
- Reset mid-operation: rst overrides everything; a pending write is discarded; data_o returns to 0.
- ce=1 while rst=1: ignored; acceptance may start on the first cycle with rst=0.

Test Plan:
- Reset: rst=1 for 2 cycles with ce=1 → data_o=0, ready=0, stall_req=1. After release with ce=0 → stall_req=0, state IDLE.
- Full-word write then read, WAIT_CYCLES=1: write addr=0x10, data_i=0xDEADBEEF, sel=1111 → ready in cycle 2, stall_req=1 in cycles 0–1. Then read addr=0x10 → data_o=0xDEADBEEF in its cycle 2.
- Byte lane write: preload word 0x00000000 at 0x20, write addr=0x21, data_i=0xABABABAB, sel=0100 → reading 0x20 returns 0x00AB0000. Then sel=0011 with data_i=0x12341234 → read returns 0x00AB1234.
- Abort: start write 0x55555555 to 0x30 (sel=1111) and drop ce in WAIT → no ready pulse, read of 0x30 returns prior value. Repeat with ce dropped in ACCESS → same result.
- Latch stability and wrap, ADDR_WIDTH=10: write 0x11111111 to addr=0x1000 (wraps to word 0). Change addr/data_i during WAIT → read of addr=0x0 returns 0x11111111.
- WAIT_CYCLES=0 and WAIT_CYCLES=3: back-to-back reads of 0x40 and 0x44 → ready spacing of 2 and 5 cycles respectively, one pulse per request, correct data each.

Source files
------------

// File: rtl/data_ram_ctrl.sv
// Data-memory responder for the MEM stage: word RAM with byte-lane writes,
// a programmable number of wait states, and a stall request until completion.
module data_ram_ctrl #(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] data_i,
   input  logic [3:0]  sel,
   output logic [31:0] data_o,
   output logic        ready,
   output logic        stall_req
);
   localparam int DATA_W = 32;
   localparam int DEPTH  = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

   state_t                state, state_nxt;
   logic [3:0]            wait_cnt;
   logic [ADDR_WIDTH-1:0] req_idx, lat_idx, rd_idx;
   logic                  lat_we, rd_we, enter_access, commit;
   logic [3:0]            lat_sel;
   logic [DATA_W-1:0]     lat_data;
   logic [DATA_W-1:0]     mem [DEPTH];
   logic                  unused_addr_bits;

   // Big-endian lanes: sel[3] owns bits 31:24, sel[0] owns bits 7:0.
   function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old_w,
                                                     input logic [DATA_W-1:0] new_w,
                                                     input logic [3:0]        lanes);
      logic [DATA_W-1:0] m;
      m = old_w;
      for (int i = 0; i < 4; i++) begin
         if (lanes[i]) m[8*i +: 8] = new_w[8*i +: 8];
      end
      return m;
   endfunction

   assign req_idx          = addr[ADDR_WIDTH+1:2];
   assign unused_addr_bits = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (ce) state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
         S_WAIT: begin
            if (!ce)                  state_nxt = S_IDLE;
            else if (wait_cnt <= 4'd1) state_nxt = S_ACCESS;
         end
         S_ACCESS: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      ready     = (state == S_ACCESS);
      stall_req = ce & ~ready;
   end

   // With zero wait states the request enters ACCESS on its accept edge,
   // so the read source comes straight from the ports in that case.
   assign enter_access = (state_nxt == S_ACCESS);
   assign rd_idx       = (state == S_IDLE) ? req_idx : lat_idx;
   assign rd_we        = (state == S_IDLE) ? we : lat_we;
   assign commit       = (state == S_ACCESS) && ce && lat_we;

   // Request latch and wait counter
   always_ff @(posedge clk) begin
      if (rst) begin
         lat_idx  <= '0;
         lat_we   <= 1'b0;
         lat_sel  <= '0;
         lat_data <= '0;
         wait_cnt <= '0;
      end else if (state == S_IDLE) begin
         if (ce) begin
            lat_idx  <= req_idx;
            lat_we   <= we;
            lat_sel  <= sel;
            lat_data <= data_i;
            wait_cnt <= 4'(WAIT_CYCLES);
         end
      end else if (state == S_WAIT) begin
         wait_cnt <= wait_cnt - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                         data_o <= '0;
      else if (enter_access && !rd_we) data_o <= mem[rd_idx];
   end

   // Write commits on the edge leaving ACCESS, so a later read sees it.
   always_ff @(posedge clk) begin
      if (commit && !rst) mem[lat_idx] <= merge_lanes(mem[lat_idx], lat_data, lat_sel);
   end

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Bench for data_ram_ctrl: three instances (0, 1 and 3 wait states) driven by
// directed and randomized accesses, checked against a word-array model.
module tb_data_ram_ctrl;
   logic        clk;
   logic        rst;
   logic        ce_v   [3];
   logic        we_v   [3];
   logic [31:0] addr_v [3];
   logic [31:0] din_v  [3];
   logic [3:0]  sel_v  [3];
   logic [31:0] dout_v [3];
   logic        rdy_v  [3];
   logic        stall_v[3];

   logic [31:0] ref_mem [3][1024];
   int          checks;
   int          failures;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int WC = (g == 0) ? 1 : (g == 1) ? 0 : 3;
      data_ram_ctrl #(.ADDR_WIDTH(10), .WAIT_CYCLES(WC)) u_dut (
         .clk(clk), .rst(rst), .ce(ce_v[g]), .we(we_v[g]), .addr(addr_v[g]),
         .data_i(din_v[g]), .sel(sel_v[g]), .data_o(dout_v[g]),
         .ready(rdy_v[g]), .stall_req(stall_v[g]));
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int wc(input int d);
      return (d == 0) ? 1 : (d == 1) ? 0 : 3;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive a request at a negedge and follow it for lat cycles; ready must
   // appear exactly at cycle lat. Leaves ce high during the ACCESS cycle.
   task automatic access(input int d, input bit w, input logic [31:0] a,
                         input logic [31:0] dat, input logic [3:0] s,
                         input int lat, input bit scramble, input string tag);
      logic [31:0] exp_rd;
      logic [31:0] m;
      exp_rd    = ref_mem[d][a[11:2]];
      ce_v[d]   = 1'b1;
      we_v[d]   = w;
      addr_v[d] = a;
      din_v[d]  = dat;
      sel_v[d]  = s;
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         if (k < lat) begin
            chk({tag, "_rdy_lo"}, 32'(rdy_v[d]), 32'd0);
            chk({tag, "_stall"}, 32'(stall_v[d]), 32'd1);
            if (scramble && k >= lat - wc(d)) begin
               we_v[d]   = 1'($urandom);
               addr_v[d] = $urandom;
               din_v[d]  = $urandom;
               sel_v[d]  = 4'($urandom);
            end
         end
      end
      chk({tag, "_rdy"}, 32'(rdy_v[d]), 32'd1);
      chk({tag, "_stall_done"}, 32'(stall_v[d]), 32'd0);
      if (!w) chk({tag, "_data"}, dout_v[d], exp_rd);
      else begin
         m = ref_mem[d][a[11:2]];
         for (int i = 0; i < 4; i++) if (s[i]) m[8*i +: 8] = dat[8*i +: 8];
         ref_mem[d][a[11:2]] = m;
      end
   endtask

   // Requester advances after the ACCESS edge, then returns to idle.
   task automatic release_ce(input int d);
      @(posedge clk);
      #1 ce_v[d] = 1'b0;
      @(negedge clk);
   endtask

   task automatic wr(input int d, input logic [31:0] a, input logic [31:0] dat,
                     input logic [3:0] s, input bit scramble, input string tag);
      access(d, 1'b1, a, dat, s, wc(d) + 1, scramble, tag);
      release_ce(d);
   endtask

   task automatic rd(input int d, input logic [31:0] a, input string tag);
      access(d, 1'b0, a, $urandom, 4'($urandom), wc(d) + 1, 1'b0, tag);
      release_ce(d);
   endtask

   // Start a write on instance 0 and drop ce at cycle at_k.
   task automatic abort_wr(input logic [31:0] a, input logic [31:0] dat,
                           input int at_k, input string tag);
      ce_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = a; din_v[0] = dat; sel_v[0] = 4'hF;
      for (int k = 1; k <= at_k; k++) @(negedge clk);
      ce_v[0] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk({tag, "_no_rdy"}, 32'(rdy_v[0]), 32'd0);
      end
   endtask

   initial begin
      logic [31:0] a, v;
      logic [9:0]  idx;
      bit          busy;
      bit          w;
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      for (int d = 0; d < 3; d++) begin
         ce_v[d] = 1'b1; we_v[d] = 1'b0; addr_v[d] = '0; din_v[d] = '0; sel_v[d] = '0;
      end
      @(negedge clk);
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk("rst_data", dout_v[d], 32'd0);
         chk("rst_ready", 32'(rdy_v[d]), 32'd0);
         chk("rst_stall", 32'(stall_v[d]), 32'd1);
      end
      rst = 1'b0;
      for (int d = 0; d < 3; d++) ce_v[d] = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) chk("idle_stall", 32'(stall_v[d]), 32'd0);
      @(negedge clk);

      // Full-word write then read, one wait state
      wr(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, "wr_full");
      rd(0, 32'h10, "rd_full");
      chk("rd_full_const", dout_v[0], 32'hDEADBEEF);

      // Byte lanes
      wr(0, 32'h20, 32'h0, 4'hF, 1'b0, "pre20");
      wr(0, 32'h21, 32'hABABABAB, 4'b0100, 1'b0, "lane1");
      rd(0, 32'h20, "rd_lane1");
      chk("lane1_const", dout_v[0], 32'h00AB0000);
      wr(0, 32'h20, 32'h12341234, 4'b0011, 1'b0, "lane2");
      rd(0, 32'h20, "rd_lane2");
      chk("lane2_const", dout_v[0], 32'h00AB1234);
      wr(0, 32'h20, 32'hFFFFFFFF, 4'b0000, 1'b0, "sel0");
      rd(0, 32'h20, "rd_sel0");
      chk("sel0_const", dout_v[0], 32'h00AB1234);

      // Aborts in WAIT and in ACCESS commit nothing
      wr(0, 32'h30, 32'h0BADF00D, 4'hF, 1'b0, "pre30");
      abort_wr(32'h30, 32'h55555555, 1, "abort_wait");
      rd(0, 32'h30, "rd_abort_wait");
      chk("abort_wait_const", dout_v[0], 32'h0BADF00D);
      abort_wr(32'h30, 32'h55555555, 2, "abort_access");
      rd(0, 32'h30, "rd_abort_access");
      chk("abort_access_const", dout_v[0], 32'h0BADF00D);

      // Latched request survives input changes; address wraps
      wr(0, 32'h1000, 32'h11111111, 4'hF, 1'b1, "wrap");
      rd(0, 32'h0, "rd_wrap");
      chk("wrap_const", dout_v[0], 32'h11111111);

      // Reset mid-write discards it and clears data_o
      rd(0, 32'h10, "pre_rst_rd");
      ce_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 32'h10; din_v[0] = 32'hCAFEF00D; sel_v[0] = 4'hF;
      @(negedge clk);
      rst = 1'b1;
      ce_v[0] = 1'b0;
      @(negedge clk);
      chk("midrst_data", dout_v[0], 32'd0);
      chk("midrst_ready", 32'(rdy_v[0]), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      rd(0, 32'h10, "rd_after_rst");
      chk("after_rst_const", dout_v[0], 32'hDEADBEEF);

      // Back-to-back reads with zero and three wait states
      for (int d = 1; d < 3; d++) begin
         wr(d, 32'h40, 32'hA5A50040 + d, 4'hF, 1'b0, "pre40");
         wr(d, 32'h44, 32'h5A5A0044 + d, 4'hF, 1'b0, "pre44");
         access(d, 1'b0, 32'h40, 32'h0, 4'h0, wc(d) + 1, 1'b0, "b2b_first");
         access(d, 1'b0, 32'h44, 32'h0, 4'h0, wc(d) + 2, 1'b0, "b2b_second");
         chk("b2b_const", dout_v[d], 32'h5A5A0044 + d);
         release_ce(d);
      end

      // Randomized traffic over a pool of preloaded words
      for (int d = 0; d < 3; d++) begin
         for (int i = 0; i < 8; i++) wr(d, 32'h400 + 4 * i, $urandom, 4'hF, 1'b0, "rnd_pre");
         busy = 1'b0;
         for (int n = 0; n < 24; n++) begin
            a = $urandom;
            idx = 10'h100 + 10'($urandom_range(0, 7));
            a[11:2] = idx;
            v = $urandom;
            w = 1'($urandom);
            access(d, w, a, v, 4'($urandom), wc(d) + (busy ? 2 : 1), 1'($urandom),
                   w ? "rnd_wr" : "rnd_rd");
            busy = 1'b1;
            if ($urandom_range(0, 1) == 0) begin
               release_ce(d);
               busy = 1'b0;
            end
         end
         if (busy) release_ce(d);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
